// File: rtl/display_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StOn
  } state_e;

  function automatic logic [N_DIGITS-1:0] digit_onehot(input logic [1:0] idx);
    logic [N_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control/data bundle between the display scan controller and its host/driver side.
interface display_scan_ctrl_if;
  import display_pkg::*;

  logic                           i_Enable;
  logic                           i_Load;
  logic [N_DIGITS*NIBBLE_W-1:0]   i_Data;
  logic [N_DIGITS-1:0]            i_DigitEn;
  logic [N_DIGITS-1:0]            o_Anodos;
  logic [1:0]                     o_Sel;
  logic [NIBBLE_W-1:0]            o_Nibble;
  logic                           o_Frame;
  logic                           o_Pending;

  modport master (
    output i_Enable, i_Load, i_Data, i_DigitEn,
    input  o_Anodos, o_Sel, o_Nibble, o_Frame, o_Pending
  );

  modport slave (
    input  i_Enable, i_Load, i_Data, i_DigitEn,
    output o_Anodos, o_Sel, o_Nibble, o_Frame, o_Pending
  );

endinterface

// File: rtl/display_slot_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module display_slot_timer #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Timed 4-digit scan with blanking gaps, per-digit mask and frame-aligned data load.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned ON_CYCLES    = 50000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input logic                i_Clk,
  input logic                i_Reset,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned MaxCycles = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam int unsigned DataW     = N_DIGITS * NIBBLE_W;

  localparam logic [CntW-1:0] OnLoad    = CntW'(ON_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLoad = CntW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // Every slot opens in BLANK unless blanking is configured away.
  localparam state_e          SlotStart = (BLANK_CYCLES == 0) ? StOn : StBlank;
  localparam logic [CntW-1:0] SlotLoad  = (BLANK_CYCLES == 0) ? OnLoad : BlankLoad;

  state_e               state_q, state_d;
  logic [1:0]           sel_q, sel_d;
  logic [DataW-1:0]     shadow_data_q, shadow_data_d;
  logic [N_DIGITS-1:0]  shadow_en_q, shadow_en_d;
  logic [DataW-1:0]     active_data_q, active_data_d;
  logic [N_DIGITS-1:0]  active_en_q, active_en_d;
  logic                 pending_q, pending_d;
  logic [N_DIGITS-1:0]  anodos_q, anodos_d;
  logic [NIBBLE_W-1:0]  nibble_q, nibble_d;
  logic                 frame_q, frame_d;

  logic                 tmr_load;
  logic [CntW-1:0]      tmr_val;
  logic                 tmr_tc;
  logic                 apply;

  display_slot_timer #(
    .Width (CntW)
  ) u_slot_timer (
    .clk_i      (i_Clk),
    .rst_ni     (i_Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    frame_d       = 1'b0;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    apply         = 1'b0;
    shadow_data_d = shadow_data_q;
    shadow_en_d   = shadow_en_q;
    active_data_d = active_data_q;
    active_en_d   = active_en_q;
    pending_d     = pending_q;

    if (!bus.i_Enable) begin
      state_d  = StIdle;
      sel_d    = '0;
      tmr_load = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = SlotStart;
          sel_d    = '0;
          frame_d  = 1'b1;
          apply    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = SlotLoad;
        end
        StBlank: begin
          if (tmr_tc) begin
            state_d  = StOn;
            tmr_load = 1'b1;
            tmr_val  = OnLoad;
          end
        end
        StOn: begin
          if (tmr_tc) begin
            state_d  = SlotStart;
            tmr_load = 1'b1;
            tmr_val  = SlotLoad;
            if (sel_q == 2'd3) begin
              sel_d   = '0;
              frame_d = 1'b1;
              apply   = 1'b1;
            end else begin
              sel_d = sel_q + 2'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // A load coinciding with a frame start goes straight to the active set.
    if (apply) begin
      if (bus.i_Load) begin
        shadow_data_d = bus.i_Data;
        shadow_en_d   = bus.i_DigitEn;
        active_data_d = bus.i_Data;
        active_en_d   = bus.i_DigitEn;
        pending_d     = 1'b0;
      end else if (pending_q) begin
        active_data_d = shadow_data_q;
        active_en_d   = shadow_en_q;
        pending_d     = 1'b0;
      end
    end else if (bus.i_Load) begin
      shadow_data_d = bus.i_Data;
      shadow_en_d   = bus.i_DigitEn;
      pending_d     = 1'b1;
    end

    anodos_d = '0;
    if (state_d == StOn && active_en_d[sel_d]) begin
      anodos_d = digit_onehot(sel_d);
    end
    nibble_d = active_data_d[{sel_d, 2'b00} +: NIBBLE_W];
  end

  always_ff @(posedge i_Clk or negedge i_Reset) begin
    if (!i_Reset) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      shadow_data_q <= '0;
      shadow_en_q   <= '0;
      active_data_q <= '0;
      active_en_q   <= '1;
      pending_q     <= 1'b0;
      anodos_q      <= '0;
      nibble_q      <= '0;
      frame_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      active_data_q <= active_data_d;
      active_en_q   <= active_en_d;
      pending_q     <= pending_d;
      anodos_q      <= anodos_d;
      nibble_q      <= nibble_d;
      frame_q       <= frame_d;
    end
  end

  assign bus.o_Anodos  = anodos_q;
  assign bus.o_Sel     = sel_q;
  assign bus.o_Nibble  = nibble_q;
  assign bus.o_Frame   = frame_q;
  assign bus.o_Pending = pending_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two configurations checked every cycle against a frame-position model.
module tb_display_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  display_scan_ctrl_if bus0 ();
  display_scan_ctrl_if bus1 ();

  display_scan_ctrl #(
    .ON_CYCLES    (4),
    .BLANK_CYCLES (2)
  ) u_dut0 (
    .i_Clk   (clk),
    .i_Reset (rst_n),
    .bus     (bus0)
  );

  display_scan_ctrl #(
    .ON_CYCLES    (1),
    .BLANK_CYCLES (0)
  ) u_dut1 (
    .i_Clk   (clk),
    .i_Reset (rst_n),
    .bus     (bus1)
  );

  int checks = 0;
  int errors = 0;

  // Model: a running scan is just a position inside the frame; everything else is arithmetic.
  int          blank_c [2] = '{2, 0};
  int          on_c    [2] = '{4, 1};
  bit          run_m   [2];
  int          pos_m   [2];
  bit          frame_m [2];
  bit          pend_m  [2];
  logic [15:0] ad_m    [2];
  logic [15:0] sd_m    [2];
  logic [3:0]  ae_m    [2];
  logic [3:0]  se_m    [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      run_m[k] = 0; pos_m[k] = 0; frame_m[k] = 0; pend_m[k] = 0;
      ad_m[k] = '0; sd_m[k] = '0; ae_m[k] = 4'hF; se_m[k] = '0;
    end
  endtask

  task automatic model_step(input int k, input bit en, input bit ld, input logic [15:0] d,
                            input logic [3:0] de);
    int  frame_len;
    bit  bnd;
    frame_len = 4 * (blank_c[k] + on_c[k]);
    bnd = 0;
    if (!en) begin
      run_m[k] = 0; pos_m[k] = 0;
    end else if (!run_m[k]) begin
      run_m[k] = 1; pos_m[k] = 0; bnd = 1;
    end else begin
      pos_m[k] = (pos_m[k] + 1) % frame_len;
      bnd = (pos_m[k] == 0);
    end
    if (bnd) begin
      if (ld) begin
        ad_m[k] = d; ae_m[k] = de; sd_m[k] = d; se_m[k] = de; pend_m[k] = 0;
      end else if (pend_m[k]) begin
        ad_m[k] = sd_m[k]; ae_m[k] = se_m[k]; pend_m[k] = 0;
      end
    end else if (ld) begin
      sd_m[k] = d; se_m[k] = de; pend_m[k] = 1;
    end
    frame_m[k] = bnd;
  endtask

  task automatic check(input int k, input logic [3:0] an, input logic [1:0] sl,
                       input logic [3:0] nb, input logic fr, input logic pd);
    int         slot;
    int         s;
    logic [3:0] exp_an;
    logic [1:0] exp_sl;
    logic [3:0] exp_nb;
    slot   = blank_c[k] + on_c[k];
    s      = run_m[k] ? pos_m[k] / slot : 0;
    exp_sl = 2'(s);
    exp_an = (run_m[k] && (pos_m[k] % slot) >= blank_c[k] && ae_m[k][s]) ? 4'(1 << s) : 4'h0;
    exp_nb = ad_m[k][4*s +: 4];
    checks++;
    assert (an === exp_an) else begin
      errors++; $error("FAIL anodos dut%0d t=%0t obs=%b exp=%b", k, $time, an, exp_an);
    end
    checks++;
    assert (sl === exp_sl) else begin
      errors++; $error("FAIL sel dut%0d t=%0t obs=%0d exp=%0d", k, $time, sl, exp_sl);
    end
    checks++;
    assert (nb === exp_nb) else begin
      errors++; $error("FAIL nibble dut%0d t=%0t obs=%h exp=%h", k, $time, nb, exp_nb);
    end
    checks++;
    assert (fr === frame_m[k]) else begin
      errors++; $error("FAIL frame dut%0d t=%0t obs=%b exp=%b", k, $time, fr, frame_m[k]);
    end
    checks++;
    assert (pd === pend_m[k]) else begin
      errors++; $error("FAIL pending dut%0d t=%0t obs=%b exp=%b", k, $time, pd, pend_m[k]);
    end
  endtask

  task automatic check_both();
    check(0, bus0.o_Anodos, bus0.o_Sel, bus0.o_Nibble, bus0.o_Frame, bus0.o_Pending);
    check(1, bus1.o_Anodos, bus1.o_Sel, bus1.o_Nibble, bus1.o_Frame, bus1.o_Pending);
  endtask

  task automatic step();
    bit          en0, ld0, en1, ld1;
    logic [15:0] d0, d1;
    logic [3:0]  de0, de1;
    en0 = bus0.i_Enable; ld0 = bus0.i_Load; d0 = bus0.i_Data; de0 = bus0.i_DigitEn;
    en1 = bus1.i_Enable; ld1 = bus1.i_Load; d1 = bus1.i_Data; de1 = bus1.i_DigitEn;
    @(posedge clk);
    model_step(0, en0, ld0, d0, de0);
    model_step(1, en1, ld1, d1, de1);
    #1;
    check_both();
  endtask

  task automatic wait_pos(input int want, input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (run_m[0] && pos_m[0] == want) begin
        found = 1;
        break;
      end
      step();
    end
    checks++;
    assert (found) else begin
      errors++; $error("FAIL wait_%s obs=timeout exp=pos%0d", tag, want);
    end
  endtask

  task automatic load0(input logic [15:0] d, input logic [3:0] de);
    bus0.i_Load = 1'b1; bus0.i_Data = d; bus0.i_DigitEn = de;
    step();
    bus0.i_Load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus0.i_Enable = 1'b0; bus0.i_Load = 1'b0; bus0.i_Data = '0; bus0.i_DigitEn = '0;
    bus1.i_Enable = 1'b0; bus1.i_Load = 1'b0; bus1.i_Data = '0; bus1.i_DigitEn = '0;
    model_reset();
    #12;
    check_both();

    // Defaults: frame 1 cycle after enable, 24-cycle frames, 4-cycle frames on dut1.
    @(negedge clk);
    rst_n = 1'b1;
    bus0.i_Enable = 1'b1;
    bus1.i_Enable = 1'b1;
    repeat (60) step();

    // Mid-frame load is held pending until the boundary.
    wait_pos(9, "sel1_on");
    load0(16'h4321, 4'b1111);
    repeat (40) step();

    // Masked digits keep their slot time.
    wait_pos(3, "mask");
    load0(16'h9A5C, 4'b0101);
    repeat (60) step();

    // Load coinciding with the frame boundary bypasses the shadow.
    wait_pos(23, "boundary");
    load0(16'hABCD, 4'b1111);
    repeat (30) step();

    // Random loads, random gaps, occasional single-cycle enable drops.
    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 14)) step();
      bus0.i_Load = 1'b1;
      bus0.i_Data = 16'($urandom);
      bus0.i_DigitEn = 4'($urandom);
      bus1.i_Load = 1'($urandom_range(0, 1));
      bus1.i_Data = 16'($urandom);
      bus1.i_DigitEn = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bus0.i_Enable = 1'b0;
      if ($urandom_range(0, 7) == 0) bus1.i_Enable = 1'b0;
      step();
      bus0.i_Load = 1'b0; bus1.i_Load = 1'b0;
      bus0.i_Enable = 1'b1; bus1.i_Enable = 1'b1;
    end
    load0(16'h1234, 4'b1111);
    repeat (30) step();

    // Enable drop during ON of digit 2, then restart.
    wait_pos(14, "sel2_on");
    bus0.i_Enable = 1'b0;
    repeat (4) step();
    bus0.i_Enable = 1'b1;
    repeat (10) step();

    // Asynchronous reset between clock edges while in BLANK.
    wait_pos(6, "blank");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_both();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
